// File: rtl/ntt_merge_pkg.sv
// rtl/ntt_merge_pkg.sv - shared constants, stage mode presets and config helpers for the NTT stream merger
package ntt_merge_pkg;

  // Source select encoding for cfg_src
  localparam logic SRC_BFA  = 1'b0;
  localparam logic SRC_MULT = 1'b1;

  // One runtime configuration of the merger as used by a given NTT stage
  typedef struct packed {
    logic [3:0] log2_grp;
    logic       src;
    logic [1:0] n_extra;
  } merge_mode_t;

  localparam merge_mode_t MODE_G256_E1      = '{log2_grp: 4'd8, src: SRC_BFA,  n_extra: 2'd1};
  localparam merge_mode_t MODE_G16_E1       = '{log2_grp: 4'd4, src: SRC_BFA,  n_extra: 2'd1};
  localparam merge_mode_t MODE_G4_E1        = '{log2_grp: 4'd2, src: SRC_BFA,  n_extra: 2'd1};
  localparam merge_mode_t MODE_G16_E2_MULT  = '{log2_grp: 4'd4, src: SRC_MULT, n_extra: 2'd2};
  localparam merge_mode_t MODE_G4_E2_MULT   = '{log2_grp: 4'd2, src: SRC_MULT, n_extra: 2'd2};

  // A config is usable only if the group fits, at least one extra slot exists,
  // the history is deep enough and the extra slots do not exceed the group.
  function automatic logic cfg_legal(input int log2_grp, input int n_extra,
                                     input int log2_max, input int max_extra);
    logic ok;
    ok = 1'b1;
    if (log2_grp > log2_max) begin
      ok = 1'b0;
    end else if (n_extra == 0 || n_extra > max_extra) begin
      ok = 1'b0;
    end else if (n_extra > (1 << log2_grp)) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Number of complete groups of stride G+1 that fit, capped by the adder lanes
  function automatic int calc_ng(input int log2_grp, input int size, input int n_adders);
    int ng;
    ng = size / ((1 << log2_grp) + 1);
    if (ng > n_adders) begin
      ng = n_adders;
    end
    return ng;
  endfunction

endpackage

// File: rtl/ntt_merge_hist.sv
// rtl/ntt_merge_hist.sv - per-lane adder result history, shifted on accepted beats
module ntt_merge_hist #(
  parameter int WIDTH    = 32,
  parameter int N_ADDERS = 51,
  parameter int DEPTH    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en_i,
  input  logic                            clr_i,
  input  logic [N_ADDERS*WIDTH-1:0]       din_i,
  output logic [DEPTH*N_ADDERS*WIDTH-1:0] hist_o
);

  // Entry 0 is one accepted beat old, entry DEPTH-1 is the oldest
  logic [DEPTH-1:0][N_ADDERS*WIDTH-1:0] hist_q;
  logic [DEPTH-1:0][N_ADDERS*WIDTH-1:0] hist_d;

  // Shift on accept; a clear alongside an accept keeps only the newest entry
  always_comb begin
    hist_d = hist_q;
    if (en_i) begin
      hist_d[0] = din_i;
      for (int k = 1; k < DEPTH; k++) begin
        hist_d[k] = clr_i ? '0 : hist_q[k-1];
      end
    end else if (clr_i) begin
      hist_d = '0;
    end
  end

  // History register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist_o = hist_q;

endmodule

// File: rtl/ntt_stream_merger.sv
// rtl/ntt_stream_merger.sv - registered valid/ready merger of NTT data and adder slots; MERGER_STATS_EN adds beat/error counters
module ntt_stream_merger #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 257,
  parameter int DATA_LEN  = 256,
  parameter int N_ADDERS  = 51,
  parameter int MAX_EXTRA = 2,
  parameter int LOG2_MAX  = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_LEN*WIDTH-1:0]          bfa_out,
  input  logic [DATA_LEN*WIDTH-1:0]          mult_out,
  input  logic [N_ADDERS*WIDTH-1:0]          adder_result,
  input  logic [$clog2(LOG2_MAX+1)-1:0]      cfg_log2_grp,
  input  logic                               cfg_src,
  input  logic [$clog2(MAX_EXTRA+1)-1:0]     cfg_n_extra,
  input  logic                               hist_clr,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SIZE*WIDTH-1:0]              output_list,
  output logic                               cfg_err,
  output logic [15:0]                        beat_cnt,
  output logic [15:0]                        err_cnt
);

  import ntt_merge_pkg::*;

  localparam int HDEPTH = (MAX_EXTRA > 1) ? MAX_EXTRA - 1 : 1;
  localparam int HK_W   = (MAX_EXTRA > 1) ? $clog2(MAX_EXTRA) : 1;

  logic accept;
  logic cfg_ok;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign cfg_ok   = cfg_legal(int'(cfg_log2_grp), int'(cfg_n_extra), LOG2_MAX, MAX_EXTRA);

  // Selected source as a word array
  logic [WIDTH-1:0] src_w [DATA_LEN];
  for (genvar w = 0; w < DATA_LEN; w++) begin : g_src
    assign src_w[w] = (cfg_src == SRC_MULT) ? mult_out[w*WIDTH +: WIDTH]
                                            : bfa_out[w*WIDTH +: WIDTH];
  end

  logic [HDEPTH*N_ADDERS*WIDTH-1:0] hist_flat;

  ntt_merge_hist #(
    .WIDTH    (WIDTH),
    .N_ADDERS (N_ADDERS),
    .DEPTH    (HDEPTH)
  ) u_hist (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (accept),
    .clr_i  (hist_clr),
    .din_i  (adder_result),
    .hist_o (hist_flat)
  );

  // hist_w[k][lane]: adder result of that lane k accepted beats ago (k=0 is the current beat)
  logic [WIDTH-1:0] hist_w [MAX_EXTRA][N_ADDERS];
  for (genvar k = 0; k < MAX_EXTRA; k++) begin : g_hk
    for (genvar ln = 0; ln < N_ADDERS; ln++) begin : g_ln
      if (k == 0) begin : g_cur
        assign hist_w[k][ln] = adder_result[ln*WIDTH +: WIDTH];
      end else begin : g_old
        assign hist_w[k][ln] = hist_flat[((k-1)*N_ADDERS + ln)*WIDTH +: WIDTH];
      end
    end
  end

  // Every slot precomputes its word for each group size, then picks by cfg_log2_grp,
  // so all slot/group/offset arithmetic folds to constants.
  logic [SIZE-1:0][WIDTH-1:0] merged;
  for (genvar s = 0; s < SIZE; s++) begin : g_slot
    logic [WIDTH-1:0] cand [LOG2_MAX+1];
    for (genvar l = 0; l <= LOG2_MAX; l++) begin : g_mode
      localparam int G   = 1 << l;
      localparam int S   = G + 1;
      localparam int GRP = s / S;
      localparam int OFF = s % S;
      localparam int NGL = calc_ng(l, SIZE, N_ADDERS);
      if (GRP >= NGL) begin : g_zero
        assign cand[l] = '0;
      end else begin : g_grp
        logic [WIDTH-1:0] data_w;
        if (OFF == 0) begin : g_nodata
          assign data_w = '0;
        end else begin : g_data
          assign data_w = src_w[GRP*G + OFF - 1];
        end
        if (OFF < MAX_EXTRA) begin : g_ext
          // slot offset j takes the history entry E-1-j, oldest first
          logic [HK_W-1:0] depth;
          assign depth   = HK_W'(int'(cfg_n_extra) - 1 - OFF);
          assign cand[l] = (int'(cfg_n_extra) > OFF) ? hist_w[depth][GRP] : data_w;
        end else begin : g_plain
          assign cand[l] = data_w;
        end
      end
    end
    assign merged[s] = cand[cfg_log2_grp];
  end

  logic                       out_valid_q, out_valid_d;
  logic                       cfg_err_q, cfg_err_d;
  logic [SIZE-1:0][WIDTH-1:0] out_list_q, out_list_d;

  // Output register: load on accept, drop valid once consumed, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    cfg_err_d   = cfg_err_q;
    out_list_d  = out_list_q;
    if (accept) begin
      out_valid_d = 1'b1;
      cfg_err_d   = !cfg_ok;
      out_list_d  = cfg_ok ? merged : '0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_list_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
      out_list_q  <= out_list_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign cfg_err     = cfg_err_q;
  assign output_list = out_list_q;

`ifdef MERGER_STATS_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating counts of accepted and illegal-config beats
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (accept && beat_cnt_q != 16'hFFFF) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
    if (accept && !cfg_ok && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign err_cnt  = err_cnt_q;
`else
  assign beat_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: doc/ntt_stream_merger.md
Name: ntt_stream_merger

Overview:
- Parametrised, pipelined successor to the combinational NTT merger stage.
- Interleaves butterfly-array or multiplier outputs with per-group adder results ("extra" slots of the non-power-of-two NTT, stride G+1) into a SIZE-word vector.
- Adds a valid/ready handshake, a registered output and a per-lane adder history of configurable depth that advances only on accepted beats.
- Group size, source and extra-slot count are selected at runtime.

Parameters:
- WIDTH, 32, word width in bits
- SIZE, 257, output words
- DATA_LEN, 256, words per source vector (SIZE-1)
- N_ADDERS, 51, adder lanes
- MAX_EXTRA, 2, max extra slots per group (history depth = MAX_EXTRA-1)
- LOG2_MAX, 8, largest legal cfg_log2_grp

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- bfa_out  in  DATA_LEN*WIDTH  butterfly-array data
- mult_out  in  DATA_LEN*WIDTH  multiplier data
- adder_result  in  N_ADDERS*WIDTH  current adder result per lane
- cfg_log2_grp  in  $clog2(LOG2_MAX+1)  log2 of data words per group G
- cfg_src  in  1  0=bfa_out, 1=mult_out
- cfg_n_extra  in  $clog2(MAX_EXTRA+1)  extra slots per group E
- hist_clr  in  1  synchronous clear of adder history
- out_valid  out  1  output_list valid
- out_ready  in  1  downstream accepts
- output_list  out  SIZE*WIDTH  merged vector
- cfg_err  out  1  held beat had illegal config
- beat_cnt  out  16  accepted beats (optional feature)
- err_cnt  out  16  illegal-config beats (optional feature)

Behaviour:
- Reset (async, rst_n=0): out_valid=0, output_list=0, cfg_err=0, history=0, counters=0.
- in_ready = !out_valid || out_ready (combinational; one output register, no skid).
- Accept: all data and cfg sampled on the same edge; the merged vector is registered; out_valid=1 next cycle. Latency 1 cycle.
- Output register holds stable while out_valid && !out_ready.
- Derived values: G = 2^cfg_log2_grp, S = G+1, NG = min(N_ADDERS, floor(SIZE/S)).
- Group i < NG, data slots: slots S*i+1 .. S*i+G take source words G*i .. G*i+G-1.
- Group i < NG, extra slots: for j = 0..E-1, slot S*i+j takes hist_k[i] with k = E-1-j, where hist_0 = current adder_result and hist_k = adder_result k accepted beats ago. Extra slots overwrite data slots.
- Slots >= NG*S are zero.
- Example values: G=256, E=1 → slot 0 = adder lane 0. G=16 → 15 groups (slots 255-256 zero). G=4 → 51 groups.
- History: per lane, depth MAX_EXTRA-1. Shifts only on accepted beats (hist_1 <= adder_result, hist_k <= hist_k-1). Stalled and idle cycles do not shift.
- hist_clr without accept: history becomes 0.
- hist_clr with accept: the current beat merges with the pre-clear history; afterwards hist_1 = adder_result and deeper entries are 0.
- Illegal config: cfg_log2_grp > LOG2_MAX, E == 0, E > MAX_EXTRA, or E > G.
  - Beat is still accepted; output_list = 0; cfg_err = 1 with that beat; history still shifts.
- cfg_err is registered alongside output_list and valid only when out_valid=1.
- Reset mid-stream discards the held beat and clears history; in_ready is 1 from the first cycle after rst_n deasserts.

Optional Feature:
- Macro: MERGER_STATS_EN.
- Defined: beat_cnt increments on each accept; err_cnt increments on each accept with illegal config. Both are 16-bit, saturate at 0xFFFF and reset to 0.
- Undefined: no counter logic; beat_cnt and err_cnt tied to 0; ports remain.

Decomposition:
- Package ntt_merge_pkg:
  - SRC_BFA/SRC_MULT constants
  - legal-config check function
  - NG computation function
  - per-stage mode constants (G=256/E=1, G=16/E=1, G=4/E=1, and the E=2 mult variants)
- Sub-module ntt_merge_hist: per-lane adder history shift register with enable and clear.

Test Plan:
1. cfg G=256 (log2 8), src=bfa, E=1; bfa word k = k+1, adder lane 0 = 0xAAAA → one cycle later out_valid=1, slot0=0xAAAA, slot k+1 = k+1.
2. cfg log2=4, src=mult, E=2; beat A lane i = 100+i, then beat B lane i = 200+i → B output: slot 17i = 100+i, slot 17i+1 = 200+i for i<15; slots 255-256 = 0.
3. out_ready=0 for 3 cycles, in_valid=1 → in_ready=0, output stable, history unshifted; release → next beat's previous slot still shows beat A's value.
4. hist_clr with accept of beat C (E=2) → C uses old history; next beat D shows C's adder value in previous slot, not 0. Then hist_clr alone → next previous slot = 0.
5. cfg log2=9 or E=0 → output_list=0, cfg_err=1; with MERGER_STATS_EN, err_cnt=1 and beat_cnt increments.
6. rst_n low mid-stall with out_valid=1 → out_valid=0, output_list=0, history 0 immediately; after release, in_ready=1.
